inst_fetch_unit: RTL

- Instruction-fetch stage. Produces the 16-bit instruction word that the decode stage splits into opcode [15:11] and func [4:0].
- Consumes the decode stage's control-flow outputs: pc_sel, jr_sel and the target addresses.
- Owns the PC and drives a request/acknowledge instruction-memory port.
- Buffers up to two fetched words: the output register plus one skid entry.

---
 rtl/inst_fetch_unit_pkg.sv | 16 +
 rtl/inst_fetch_unit_skid_buf.sv | 41 ++++
 rtl/inst_fetch_unit.sv | 81 ++++++++
 3 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// inst_fetch_unit_pkg: shared encodings, field positions and state type for the fetch stage
package inst_fetch_unit_pkg;
  localparam logic [1:0] PC_SEL_SEQ = 2'b00;
  localparam logic [1:0] PC_SEL_BR  = 2'b01;
  localparam logic [1:0] PC_SEL_JMP = 2'b10;
  localparam logic [1:0] PC_SEL_RSV = 2'b11;
  localparam logic [15:0] NOP_INST = 16'h0000;
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 11;
  localparam int FUNC_MSB = 4;
  localparam int FUNC_LSB = 0;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fetch_state_t;
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return v + 16'(en && v != 16'hFFFF);
  endfunction
endpackage

// File: rtl/inst_fetch_unit_skid_buf.sv
// fetch_skid_buf: output register plus one skid entry of {pc,inst}, with push/pop/flush
module fetch_skid_buf
  import inst_fetch_unit_pkg::*;
#(
  parameter int AW = 16,
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [AW-1:0] push_pc,
  input  logic [IW-1:0] push_inst,
  output logic          out_valid,
  output logic [AW-1:0] out_pc,
  output logic [IW-1:0] out_inst,
  output logic [1:0]    occ
);
  logic skid_v;
  logic [AW+IW-1:0] out_d, skid_d;
  assign {out_pc, out_inst} = out_d;
  assign occ = 2'(out_valid) + 2'(skid_v);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      skid_v <= 1'b0;
      out_d <= {AW'(0), IW'(NOP_INST)};
      skid_d <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      skid_v <= 1'b0;
    end else begin
      if (push) skid_d <= {push_pc, push_inst};
      if (pop || !out_valid) begin
        if (skid_v || push) out_d <= skid_v ? skid_d : {push_pc, push_inst};
        out_valid <= skid_v || push;
        skid_v <= skid_v && push;
      end else if (push) skid_v <= 1'b1;
    end
endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: PC, req/ack instruction port and 2-deep output buffer feeding decode.
// FETCH_STATS_EN adds saturating redirect/stall/discard counters.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int AW = 16,
  parameter int IW = 16,
  parameter logic [AW-1:0] RESET_VEC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_rdata,
  input  logic          stall,
  input  logic [1:0]    pc_sel,
  input  logic          jr_sel,
  input  logic [AW-1:0] br_target,
  input  logic [AW-1:0] jmp_target,
  input  logic [AW-1:0] jr_target,
  output logic          if_valid,
  output logic [IW-1:0] if_inst,
  output logic [AW-1:0] if_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]   stat_redirects,
  output logic [15:0]   stat_stall_cycles,
  output logic [15:0]   stat_drain_discards
`endif
);
  fetch_state_t state, state_nx;
  logic [AW-1:0] pc, pc_nx, req_addr, target;
  logic pend, redirect, accept, consume, ack, push;
  logic [1:0] occ, occ_after;
  assign redirect = jr_sel || pc_sel == PC_SEL_BR || pc_sel == PC_SEL_JMP;
  assign target = jr_sel ? jr_target : pc_sel == PC_SEL_BR ? br_target : jmp_target;
  assign accept = redirect && state != IDLE;
  assign consume = if_valid && !stall;
  assign occ_after = occ - 2'(consume);
  // A raised request is held (pend) with its address frozen until acknowledged.
  assign imem_req = pend || (state == FETCH && occ_after < 2'd2);
  assign imem_addr = pend ? req_addr : pc;
  assign ack = imem_req && imem_ack;
  assign push = ack && state == FETCH && !accept;
  always_comb begin
    state_nx = state == IDLE ? FETCH :
               state == FETCH ? ((accept && imem_req && !imem_ack) ? DRAIN : FETCH) :
               (imem_ack ? FETCH : DRAIN);
    pc_nx = accept ? target : push ? imem_addr + 1'b1 : pc;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pc <= RESET_VEC;
      pend <= 1'b0;
      req_addr <= RESET_VEC;
    end else begin
      state <= state_nx;
      pc <= pc_nx;
      pend <= imem_req && !imem_ack;
      req_addr <= imem_addr;
    end
  fetch_skid_buf #(.AW(AW), .IW(IW)) u_buf (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(consume), .flush(accept),
    .push_pc(imem_addr), .push_inst(imem_rdata),
    .out_valid(if_valid), .out_pc(if_pc), .out_inst(if_inst), .occ(occ)
  );
`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stat_redirects <= '0;
      stat_stall_cycles <= '0;
      stat_drain_discards <= '0;
    end else begin
      stat_redirects <= sat_inc(stat_redirects, accept);
      stat_stall_cycles <= sat_inc(stat_stall_cycles, if_valid && stall);
      stat_drain_discards <= sat_inc(stat_drain_discards, ack && (state == DRAIN || accept));
    end
`endif
endmodule
